// File: rtl/stream_mux_pkg.sv
// Shared definitions for the registered stream multiplexer.
//   MODE_SEL / MODE_RR : selection modes for stream_mux_rr
//   clog2 / sel_width  : elaboration-time helpers for index widths
package stream_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A channel index needs at least one bit, even for a single channel.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: combinational search starting at i_ptr and wrapping
// modulo N_CH. The first requesting channel found wins.
//   i_req   : per-channel request
//   i_ptr   : highest-priority channel index for this arbitration
//   o_grant : one-hot grant (zero when nothing requests)
//   o_idx   : index of the granted channel (zero when nothing requests)
//   o_any   : at least one channel granted
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_grant,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            j = (int'(i_ptr) + k) % N_CH;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Selection is either by the external sel input (MODE_SEL) or by round-robin
// arbitration among valid channels (MODE_RR).
//   clk, rst   : single clock, synchronous active-high reset
//   in_valid   : per-channel valid
//   in_data    : packed channel data, channel i at [i*DATA_W +: DATA_W]
//   in_ready   : per-channel ready, at most one bit high
//   sel        : channel select (MODE_SEL only)
//   out_valid  : registered output valid
//   out_data   : registered output data
//   out_ch     : index of the channel that supplied out_data
//   out_ready  : consumer ready
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = MODE_SEL,
    parameter int SEL_W  = sel_width(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  r_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_ch;

    logic              w_load_en;
    logic [N_CH-1:0]   w_sel_grant;
    logic [SEL_W-1:0]  w_sel_idx;
    logic [N_CH-1:0]   w_rr_grant;
    logic [SEL_W-1:0]  w_rr_idx;
    logic              w_rr_any;
    logic [N_CH-1:0]   w_grant;
    logic [SEL_W-1:0]  w_idx;
    logic [N_CH-1:0]   w_in_ready;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data;
    logic [SEL_W-1:0]  w_ptr_next;

    // The output register can take a new beat when empty or draining now.
    assign w_load_en = !r_out_valid || out_ready;

    // Compare sel against every legal index, so an out-of-range sel simply
    // matches nothing instead of indexing past in_valid.
    always_comb begin
        w_sel_grant = '0;
        w_sel_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_sel_grant[i] = 1'b1;
                w_sel_idx      = SEL_W'(i);
            end
        end
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

    assign w_grant = (MODE == MODE_RR) ? w_rr_grant : w_sel_grant;
    assign w_idx   = (MODE == MODE_RR) ? w_rr_idx   : w_sel_idx;

    // Grants are only ever given to valid channels, so any ready bit high
    // means a transfer happens this cycle. rst gates ready so nothing is
    // accepted while the block is held in reset.
    assign w_in_ready = (!rst && w_load_en) ? w_grant : '0;
    assign w_xfer     = |w_in_ready;
    assign in_ready   = w_in_ready;

    // One-hot grant lets the data select be a plain AND-OR.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant[i]) begin
                w_data = w_data | in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_ptr_next = (w_idx == SEL_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_ch    <= w_idx;
            if (MODE == MODE_RR && w_rr_any) begin
                r_ptr <= w_ptr_next;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr. Two instances share the clock: a 5-channel
// 2-bit MODE_SEL mux (5 channels so that sel=5 is representable and out of
// range) and a 4-channel 8-bit MODE_RR mux. Accepted beats are predicted into
// per-instance queues before the edge and compared after it.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // MODE_SEL instance
    logic [4:0] s_in_valid;
    logic [9:0] s_in_data;
    logic [4:0] s_in_ready;
    logic [2:0] s_sel;
    logic       s_out_valid;
    logic [1:0] s_out_data;
    logic [2:0] s_out_ch;
    logic       s_out_ready;

    // MODE_RR instance
    logic [3:0]  r_in_valid;
    logic [31:0] r_in_data;
    logic [3:0]  r_in_ready;
    logic [1:0]  r_sel;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [1:0]  r_out_ch;
    logic        r_out_ready;

    stream_mux_rr #(.N_CH(5), .DATA_W(2), .MODE(MODE_SEL)) u_sel (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .sel       (s_sel),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ch    (s_out_ch),
        .out_ready (s_out_ready)
    );

    stream_mux_rr #(.N_CH(4), .DATA_W(8), .MODE(MODE_RR)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_in_valid),
        .in_data   (r_in_data),
        .in_ready  (r_in_ready),
        .sel       (r_sel),
        .out_valid (r_out_valid),
        .out_data  (r_out_data),
        .out_ch    (r_out_ch),
        .out_ready (r_out_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard entries: {channel[15:8], data[7:0]}
    logic [15:0] s_q[$];
    logic [15:0] r_q[$];
    int          rr_ptr = 0;

    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic [4:0] sg;
        logic [3:0] rg;
        int         sidx;
        int         j;
        int         jw;
        bit         found;
        #1;
        if (rst) begin
            check("sel_in_ready_rst", 32'(s_in_ready), 32'd0);
            check("rr_in_ready_rst",  32'(r_in_ready), 32'd0);
        end else begin
            sg   = '0;
            sidx = int'(s_sel);
            if (s_q.size() == 0 || s_out_ready) begin
                if (sidx < 5) begin
                    if (s_in_valid[sidx]) sg[sidx] = 1'b1;
                end
            end
            check("sel_in_ready", 32'(s_in_ready), 32'(sg));
            if (s_q.size() != 0 && s_out_ready) void'(s_q.pop_front());
            if (sg != 0) s_q.push_back({8'(sidx), 6'd0, s_in_data[sidx*2 +: 2]});

            rg    = '0;
            found = 1'b0;
            jw    = 0;
            if (r_q.size() == 0 || r_out_ready) begin
                for (int k = 0; k < 4; k++) begin
                    j = (rr_ptr + k) % 4;
                    if (!found && r_in_valid[j]) begin
                        found = 1'b1;
                        jw    = j;
                        rg[j] = 1'b1;
                    end
                end
            end
            check("rr_in_ready", 32'(r_in_ready), 32'(rg));
            if (r_q.size() != 0 && r_out_ready) void'(r_q.pop_front());
            if (found) begin
                r_q.push_back({8'(jw), r_in_data[jw*8 +: 8]});
                rr_ptr = (jw + 1) % 4;
            end
        end

        @(posedge clk);
        #1;
        if (rst) begin
            s_q.delete();
            r_q.delete();
            rr_ptr = 0;
            check("sel_out_valid_rst", 32'(s_out_valid), 32'd0);
            check("sel_out_data_rst",  32'(s_out_data),  32'd0);
            check("rr_out_valid_rst",  32'(r_out_valid), 32'd0);
            check("rr_out_data_rst",   32'(r_out_data),  32'd0);
            check("rr_out_ch_rst",     32'(r_out_ch),    32'd0);
        end else begin
            check("sel_out_valid", 32'(s_out_valid), 32'(s_q.size() != 0));
            if (s_q.size() != 0) begin
                check("sel_out_data", 32'(s_out_data), 32'(s_q[0][7:0]));
                check("sel_out_ch",   32'(s_out_ch),   32'(s_q[0][15:8]));
            end
            check("rr_out_valid", 32'(r_out_valid), 32'(r_q.size() != 0));
            if (r_q.size() != 0) begin
                check("rr_out_data", 32'(r_out_data), 32'(r_q[0][7:0]));
                check("rr_out_ch",   32'(r_out_ch),   32'(r_q[0][15:8]));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        s_in_valid  = 5'b11111;
        s_in_data   = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        s_sel       = 3'd0;
        s_out_ready = 1'b1;
        r_in_valid  = 4'b1111;
        r_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        r_sel       = 2'd0;
        r_out_ready = 1'b1;
        @(negedge clk);

        // Reset held for three cycles with every channel valid
        repeat (3) step();
        rst = 1'b0;

        // sel stepping 3,2,1,0 then drain; RR rotation with all valid
        for (int n = 0; n < 6; n++) begin
            if (n < 4) s_sel = 3'(3 - n);
            if (n == 4) s_in_valid = '0;
            step();
            if (n < 4) begin
                check("sel_step_data", 32'(s_out_data), 32'(3 - n));
                check("sel_step_ch",   32'(s_out_ch),   32'(3 - n));
            end
            check("rr_rotate", 32'(r_out_ch), 32'(rr_exp[n]));
        end

        // Backpressure on both; sel changes while held must not take effect
        r_out_ready = 1'b0;
        s_in_valid  = 5'b11111;
        s_sel       = 3'd1;
        s_out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            s_sel = 3'd3;
            check("bp_hold_ch", 32'(r_out_ch),   32'd1);
            check("bp_ready",   32'(r_in_ready), 32'd0);
            check("sel_hold",   32'(s_out_data), 32'd1);
        end
        r_out_ready = 1'b1;
        s_out_ready = 1'b1;
        step();
        check("bp_resume",      32'(r_out_ch),   32'd2);
        check("sel_after_hold", 32'(s_out_data), 32'd3);

        // Sparse RR: ch1/ch3 valid, then only ch3; sel out of range drains
        r_in_valid = 4'b1010;
        s_sel      = 3'd2;
        step();
        check("sparse_ch3",  32'(r_out_ch),   32'd3);
        check("sel_two",     32'(s_out_data), 32'd2);
        s_sel = 3'd5;
        step();
        check("sparse_wrap", 32'(r_out_ch),    32'd1);
        check("sel_oob",     32'(s_out_valid), 32'd0);
        r_in_valid = 4'b1000;
        step();
        check("sparse_only3", 32'(r_out_ch), 32'd3);
        step();
        check("sparse_skip",  32'(r_out_ch), 32'd3);

        // Reset mid-stream drops the held beat and returns the pointer to 0
        r_in_valid = 4'b1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rr_after_rst", 32'(r_out_ch), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
